// File: rtl/match_pkg.sv
// match_pkg: shared state encoding and default parameters for the tug-of-war match controller
package match_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, POINT, MATCH_OVER} match_state_t;
    localparam int WIN_SCORE_DEF = 7;
    localparam int HOLD_CYCLES_DEF = 4;
endpackage

// File: rtl/score_counter.sv
// score_counter: per-player point counter with clear priority and win-look-ahead
module score_counter #(
    parameter int SCORE_W = 3,
    parameter int WIN_SCORE = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] count,
    output logic               hit
);
    assign hit = ({1'b0, count} + (SCORE_W+1)'(inc)) == (SCORE_W+1)'(WIN_SCORE);
    always_ff @(posedge clk) begin
        if (!reset) count <= '0;
        else count <= clr ? '0 : count + SCORE_W'(inc);
    end
    always_ff @(posedge clk) begin
        if (reset && !clr) assert (!(inc && count == SCORE_W'(WIN_SCORE)));
    end
endmodule

// File: rtl/match_controller.sv
// match_controller: arbitrates presses into move grants, scores rounds and sequences the match
module match_controller import match_pkg::*; #(
    parameter int WIN_SCORE = WIN_SCORE_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int SCORE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               press_l,
    input  logic               press_r,
    input  logic               edge_l,
    input  logic               edge_r,
    output logic               move_l,
    output logic               move_r,
    output logic               field_clr,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               winner_l,
    output logic               winner_r,
    output logic               playing
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    match_state_t state, state_nxt;
    logic [HW-1:0] hold;
    logic in_play, sole_l, sole_r, pt_l, pt_r, pt, go, hit_l, hit_r;
    always_comb begin
        in_play = state == PLAY;
        sole_l = press_l & ~press_r;
        sole_r = press_r & ~press_l;
        pt_l = in_play & sole_l & edge_l;
        pt_r = in_play & sole_r & edge_r;
        pt = pt_l | pt_r;
        go = start & (state == IDLE | state == MATCH_OVER);
    end
    score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score_l (
        .clk(clk), .reset(reset), .clr(go), .inc(pt_l), .count(score_l), .hit(hit_l)
    );
    score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score_r (
        .clk(clk), .reset(reset), .clr(go), .inc(pt_r), .count(score_r), .hit(hit_r)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            hold <= '0;
            move_l <= 1'b0;
            move_r <= 1'b0;
        end else begin
            state <= state_nxt;
            hold <= (go | (pt & state_nxt == POINT)) ? HW'(HOLD_CYCLES) : state == POINT ? hold - 1'b1 : hold;
            move_l <= in_play & sole_l & ~edge_l;
            move_r <= in_play & sole_r & ~edge_r;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? POINT : IDLE;
            PLAY:    state_nxt = ((pt_l & hit_l) | (pt_r & hit_r)) ? MATCH_OVER : pt ? POINT : PLAY;
            POINT:   state_nxt = hold == HW'(1) ? PLAY : POINT;
            default: state_nxt = start ? POINT : MATCH_OVER;
        endcase
    end
    always_comb begin
        field_clr = state != PLAY;
        playing = state == PLAY;
        winner_l = state == MATCH_OVER && score_l == SCORE_W'(WIN_SCORE);
        winner_r = state == MATCH_OVER && score_r == SCORE_W'(WIN_SCORE);
    end
endmodule
